// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// registers the IF/ID pipeline and runs the Stop -> DRAIN -> HALTED sequence.
module if_stage #(
    parameter int unsigned                  DATA_WIDTH   = 16,
    parameter int unsigned                  ADDR_WIDTH   = 8,
    parameter int unsigned                  IMM8_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0]        NOP_INSTR    = 16'h0000,
    parameter int unsigned                  DRAIN_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDR_WIDTH-1:0]   instr_mem_addr_o,
    input  logic [DATA_WIDTH-1:0]   instr_mem_rD_i,
    input  logic                    stall_IF_ID_i,
    input  logic                    flush_IF_ID_i,
    input  logic                    Jump_i,
    input  logic [IMM8_WIDTH-1:0]   jumpAddr_i,
    input  logic                    BranchTaken_i,
    input  logic [ADDR_WIDTH-1:0]   branchAddr_i,
    input  logic                    Stop_i,
    output logic [ADDR_WIDTH-1:0]   PCD_o,
    output logic [DATA_WIDTH-1:0]   instruction_D_o,
    output logic                    halted_o,
    output logic [15:0]             fetch_count_o
);

    localparam int unsigned DRAIN_W = 4;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  pcd_q, pcd_d;
    logic [DATA_WIDTH-1:0]  instr_q, instr_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Sequential state: PC, IF/ID register, FSM, drain counter, fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            pcd_q   <= '0;
            instr_q <= NOP_INSTR;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcd_q   <= pcd_d;
            instr_q <= instr_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: redirect/stall/stop priority in RUN, bubbles in DRAIN, freeze in HALTED
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pcd_d   = pcd_q;
        instr_d = instr_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_RUN: begin
                if (BranchTaken_i) begin
                    // Branch is the older instruction, so it beats everything else
                    pc_d    = branchAddr_i;
                    pcd_d   = '0;
                    instr_d = NOP_INSTR;
                end else if (stall_IF_ID_i) begin
                    pc_d    = pc_q;
                end else if (Stop_i) begin
                    pcd_d   = '0;
                    instr_d = NOP_INSTR;
                    drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                    state_d = S_DRAIN;
                end else if (Jump_i) begin
                    pc_d    = ADDR_WIDTH'(jumpAddr_i);
                    pcd_d   = '0;
                    instr_d = NOP_INSTR;
                end else if (flush_IF_ID_i) begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    pcd_d   = '0;
                    instr_d = NOP_INSTR;
                end else begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    pcd_d   = pc_q;
                    instr_d = instr_mem_rD_i;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                pcd_d   = '0;
                instr_d = NOP_INSTR;
                if (drain_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs: memory address is the PC; everything else is straight from registers
    assign instr_mem_addr_o = pc_q;
    assign PCD_o            = pcd_q;
    assign instruction_D_o  = instr_q;
    assign halted_o         = (state_q == S_HALTED);
    assign fetch_count_o    = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, redirects, stall/flush, wrap, drain/halt, saturation.
`timescale 1ns/1ps
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [7:0]  instr_mem_addr;
    logic [15:0] instr_mem_rd;
    logic        stall;
    logic        flush;
    logic        jump;
    logic [7:0]  jump_addr;
    logic        branch;
    logic [7:0]  branch_addr;
    logic        stop;
    logic [7:0]  pcd;
    logic [15:0] instr_d;
    logic        halted;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .instr_mem_addr_o (instr_mem_addr),
        .instr_mem_rD_i   (instr_mem_rd),
        .stall_IF_ID_i    (stall),
        .flush_IF_ID_i    (flush),
        .Jump_i           (jump),
        .jumpAddr_i       (jump_addr),
        .BranchTaken_i    (branch),
        .branchAddr_i     (branch_addr),
        .Stop_i           (stop),
        .PCD_o            (pcd),
        .instruction_D_o  (instr_d),
        .halted_o         (halted),
        .fetch_count_o    (fetch_count)
    );

    // Combinational instruction memory: word = {8'hA0, addr}
    assign instr_mem_rd = {8'hA0, instr_mem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; jump = 0; jump_addr = '0;
        branch = 0; branch_addr = '0; stop = 0;
    endtask

    task automatic check_state(input string tag, input logic [7:0] pc_e, input logic [7:0] pcd_e,
                               input logic [15:0] ins_e, input logic hlt_e, input logic [15:0] cnt_e);
        check({tag, ".pc"},    32'(instr_mem_addr), 32'(pc_e));
        check({tag, ".pcd"},   32'(pcd),            32'(pcd_e));
        check({tag, ".instr"}, 32'(instr_d),        32'(ins_e));
        check({tag, ".halt"},  32'(halted),         32'(hlt_e));
        check({tag, ".cnt"},   32'(fetch_count),    32'(cnt_e));
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        check_state("reset", 8'h00, 8'h00, 16'h0000, 1'b0, 16'd0);

        // Free run three fetches
        tick(); tick(); tick();
        check_state("run3", 8'h03, 8'h02, 16'hA002, 1'b0, 16'd3);
        tick(); tick();
        check_state("run5", 8'h05, 8'h04, 16'hA004, 1'b0, 16'd5);

        // Jump at PC=5
        jump = 1; jump_addr = 8'h40;
        tick();
        check_state("jump", 8'h40, 8'h00, 16'h0000, 1'b0, 16'd5);
        clear_inputs();
        tick();
        check_state("jump_next", 8'h41, 8'h40, 16'hA040, 1'b0, 16'd6);

        // Stall holds even with Jump asserted
        stall = 1; jump = 1; jump_addr = 8'h55;
        tick();
        check_state("stall1", 8'h41, 8'h40, 16'hA040, 1'b0, 16'd6);
        tick();
        check_state("stall2", 8'h41, 8'h40, 16'hA040, 1'b0, 16'd6);

        // Branch overrides stall
        branch = 1; branch_addr = 8'h10;
        tick();
        check_state("br_stall", 8'h10, 8'h00, 16'h0000, 1'b0, 16'd6);
        clear_inputs();

        // PC wrap 8'hFF -> 8'h00
        branch = 1; branch_addr = 8'hFF;
        tick();
        clear_inputs();
        check("pc_ff", 32'(instr_mem_addr), 32'h0000_00FF);
        tick();
        check_state("wrap", 8'h00, 8'hFF, 16'hA0FF, 1'b0, 16'd7);

        // Stop together with branch: branch wins, stays in RUN
        stop = 1; branch = 1; branch_addr = 8'h22;
        tick();
        check_state("stop_br", 8'h22, 8'h00, 16'h0000, 1'b0, 16'd7);
        clear_inputs();
        tick();
        check_state("stop_br_run", 8'h23, 8'h22, 16'hA022, 1'b0, 16'd8);

        // Flush with stall: stall wins
        flush = 1; stall = 1;
        tick();
        check_state("flush_stall", 8'h23, 8'h22, 16'hA022, 1'b0, 16'd8);
        stall = 0;
        tick();
        check_state("flush", 8'h24, 8'h00, 16'h0000, 1'b0, 16'd8);
        clear_inputs();

        // Stop at PC=7 -> DRAIN x3 -> HALTED, ignoring redirects
        branch = 1; branch_addr = 8'h07;
        tick();
        clear_inputs();
        stop = 1;
        tick();
        check_state("stop", 8'h07, 8'h00, 16'h0000, 1'b0, 16'd8);
        clear_inputs();
        jump = 1; jump_addr = 8'h99; branch = 1; branch_addr = 8'h33;
        tick();
        check_state("drain1", 8'h07, 8'h00, 16'h0000, 1'b0, 16'd8);
        tick();
        check_state("drain2", 8'h07, 8'h00, 16'h0000, 1'b0, 16'd8);
        tick();
        check_state("halted", 8'h07, 8'h00, 16'h0000, 1'b1, 16'd8);
        tick();
        check_state("halted_hold", 8'h07, 8'h00, 16'h0000, 1'b1, 16'd8);
        clear_inputs();

        // Reset exits HALTED
        rst = 1;
        tick();
        rst = 0;
        check_state("rst_halt", 8'h00, 8'h00, 16'h0000, 1'b0, 16'd0);

        // Fetch counter saturates at 16'hFFFF
        for (int i = 0; i < 65540; i++) tick();
        check("sat_cnt", 32'(fetch_count), 32'h0000_FFFF);
        check("sat_pc",  32'(instr_mem_addr), 32'h0000_0004);
        check("sat_pcd", 32'(pcd), 32'h0000_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
